// File: rtl/gm_draw_pkg.sv
// rtl/gm_draw_pkg.sv - shared types for the Gold Miner draw scheduler
package gm_draw_pkg;

    localparam int X_W     = 9;
    localparam int Y_W     = 8;
    localparam int COLOR_W = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_START,
        ST_WAIT,
        ST_FINISH
    } sched_state_t;

    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [COLOR_W-1:0] color;
        logic               we;
    } pixel_t;

endpackage

// File: rtl/draw_port_mux.sv
// rtl/draw_port_mux.sv - registered N-to-1 pixel mux feeding the VGA plot port
module draw_port_mux
    import gm_draw_pkg::*;
#(
    parameter int N_CLIENTS = 4,
    parameter int IDX_W     = 2
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  pixel_t [N_CLIENTS-1:0] pix_i,
    input  logic [IDX_W-1:0]       sel_i,
    input  logic                   gate_i,
    output pixel_t                 pix_o
);

    pixel_t sel_pix;
    pixel_t pix_q;

    // Select the bundle of the client currently owning the port.
    always_comb begin
        sel_pix = pix_i[sel_i];
    end

    // Coordinates always follow the selected client; the write strobe only
    // escapes while the gate is open, so idle/select/start cycles never plot.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pix_q <= '0;
        end else begin
            pix_q.x     <= sel_pix.x;
            pix_q.y     <= sel_pix.y;
            pix_q.color <= sel_pix.color;
            pix_q.we    <= sel_pix.we & gate_i;
        end
    end

    assign pix_o = pix_q;

endmodule

// File: rtl/draw_scheduler.sv
// rtl/draw_scheduler.sv - per-frame draw client sequencer and plot-port arbiter
module draw_scheduler
    import gm_draw_pkg::*;
#(
    parameter int N_CLIENTS = 4,
    parameter int TIMEOUT   = 200000
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         frame_tick,
    input  logic [N_CLIENTS-1:0]         client_mask,
    input  logic [X_W*N_CLIENTS-1:0]     client_x,
    input  logic [Y_W*N_CLIENTS-1:0]     client_y,
    input  logic [COLOR_W*N_CLIENTS-1:0] client_color,
    input  logic [N_CLIENTS-1:0]         client_we,
    input  logic [N_CLIENTS-1:0]         client_done,
    output logic [N_CLIENTS-1:0]         client_en,
    output logic [X_W-1:0]               vga_x,
    output logic [Y_W-1:0]               vga_y,
    output logic [COLOR_W-1:0]           vga_color,
    output logic                         vga_plot,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         overrun,
    output logic [N_CLIENTS-1:0]         timeout_flags,
    output logic [$clog2(N_CLIENTS)-1:0] cur_client
);

    localparam int IDX_W = $clog2(N_CLIENTS);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLIENTS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    sched_state_t state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [N_CLIENTS-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [N_CLIENTS-1:0] flags_q, flags_d;

    logic sel_done;
    logic wait_expired;
    logic last_idx;

    pixel_t [N_CLIENTS-1:0] pix;
    pixel_t                 vga_pix;

    assign sel_done     = client_done[idx_q];
    assign wait_expired = (cnt_q == CNT_LAST);
    assign last_idx     = (idx_q == LAST_IDX);

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            flags_q <= flags_d;
        end
    end

    // Next-state: walk the latched mask in index order, one client at a time.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        flags_d = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_tick) begin
                    mask_d  = client_mask;
                    idx_d   = '0;
                    flags_d = '0;
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (mask_q[idx_q]) begin
                    state_d = ST_START;
                end else if (last_idx) begin
                    state_d = ST_FINISH;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Saturating so a very long wait can never alias back to zero.
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (sel_done || wait_expired) begin
                    // A done in the expiry cycle still counts as a clean finish.
                    if (!sel_done) begin
                        flags_d[idx_q] = 1'b1;
                    end
                    if (last_idx) begin
                        state_d = ST_FINISH;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_SELECT;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Start pulse is decoded purely from registered state.
    always_comb begin
        client_en = '0;
        if (state_q == ST_START) begin
            client_en[idx_q] = 1'b1;
        end
    end

    assign busy          = (state_q != ST_IDLE);
    assign frame_done    = (state_q == ST_FINISH);
    assign overrun       = frame_tick & (state_q != ST_IDLE);
    assign timeout_flags = flags_q;
    assign cur_client    = idx_q;

    // Unpack the per-client buses into pixel bundles for the port mux.
    always_comb begin
        pix = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            pix[i].x     = client_x[X_W*i +: X_W];
            pix[i].y     = client_y[Y_W*i +: Y_W];
            pix[i].color = client_color[COLOR_W*i +: COLOR_W];
            pix[i].we    = client_we[i];
        end
    end

    draw_port_mux #(
        .N_CLIENTS (N_CLIENTS),
        .IDX_W     (IDX_W)
    ) u_port_mux (
        .clock  (clock),
        .resetn (resetn),
        .pix_i  (pix),
        .sel_i  (idx_q),
        .gate_i (state_q == ST_WAIT),
        .pix_o  (vga_pix)
    );

    assign vga_x     = vga_pix.x;
    assign vga_y     = vga_pix.y;
    assign vga_color = vga_pix.color;
    assign vga_plot  = vga_pix.we;

endmodule

// File: tb/tb_draw_scheduler.sv
// tb/tb_draw_scheduler.sv - randomized scoreboard bench for draw_scheduler
`timescale 1ns/1ps
module tb_draw_scheduler;

    localparam int N   = 4;
    localparam int TMO = 16;

    logic        clock = 1'b0;
    logic        resetn;
    logic        frame_tick;
    logic [3:0]  client_mask;
    logic [35:0] client_x;
    logic [31:0] client_y;
    logic [47:0] client_color;
    logic [3:0]  client_we;
    logic [3:0]  client_done;
    logic [3:0]  client_en;
    logic [8:0]  vga_x;
    logic [7:0]  vga_y;
    logic [11:0] vga_color;
    logic        vga_plot;
    logic        busy;
    logic        frame_done;
    logic        overrun;
    logic [3:0]  timeout_flags;
    logic [1:0]  cur_client;

    always #5 clock = ~clock;

    draw_scheduler #(.N_CLIENTS(N), .TIMEOUT(TMO)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .frame_tick    (frame_tick),
        .client_mask   (client_mask),
        .client_x      (client_x),
        .client_y      (client_y),
        .client_color  (client_color),
        .client_we     (client_we),
        .client_done   (client_done),
        .client_en     (client_en),
        .vga_x         (vga_x),
        .vga_y         (vga_y),
        .vga_color     (vga_color),
        .vga_plot      (vga_plot),
        .busy          (busy),
        .frame_done    (frame_done),
        .overrun       (overrun),
        .timeout_flags (timeout_flags),
        .cur_client    (cur_client)
    );

    typedef struct { int cyc; logic [3:0] val; } en_ev_t;
    typedef struct { int cyc; logic [8:0] x; logic [7:0] y; logic [11:0] c; } plot_ev_t;
    typedef struct { int cyc; logic bsy; logic [1:0] cur; logic [3:0] flags; } st_ev_t;

    en_ev_t   en_q[$];
    plot_ev_t plot_q[$];
    st_ev_t   st_q[$];
    int       fd_q[$];
    int       ov_q[$];

    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    bit         chk_en = 1'b0;
    int         dly[4];
    logic [1:0] cur_idle;
    logic [3:0] prev_flags;

    en_ev_t   m_en;
    plot_ev_t m_pl;
    st_ev_t   m_st;
    int       m_c;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    always @(negedge clock) begin
        if (chk_en) begin
            if (st_q.size() > 0) begin
                m_st = st_q.pop_front();
                check("busy", 64'(busy), 64'(m_st.bsy));
                check("cur_client", 64'(cur_client), 64'(m_st.cur));
                check("timeout_flags", 64'(timeout_flags), 64'(m_st.flags));
            end
            if (client_en != 4'b0000) begin
                if (en_q.size() == 0) check("client_en_unexpected", 64'(client_en), 64'd0);
                else begin
                    m_en = en_q.pop_front();
                    check("client_en_cycle", 64'(cyc), 64'(m_en.cyc));
                    check("client_en_value", 64'(client_en), 64'(m_en.val));
                end
            end
            if (frame_done) begin
                if (fd_q.size() == 0) check("frame_done_unexpected", 64'd1, 64'd0);
                else begin
                    m_c = fd_q.pop_front();
                    check("frame_done_cycle", 64'(cyc), 64'(m_c));
                end
            end
            if (overrun) begin
                if (ov_q.size() == 0) check("overrun_unexpected", 64'd1, 64'd0);
                else begin
                    m_c = ov_q.pop_front();
                    check("overrun_cycle", 64'(cyc), 64'(m_c));
                end
            end
            if (vga_plot) begin
                if (plot_q.size() == 0) check("plot_unexpected", {35'd0, vga_x, vga_y, vga_color}, 64'd0);
                else begin
                    m_pl = plot_q.pop_front();
                    check("plot_cycle", 64'(cyc), 64'(m_pl.cyc));
                    check("plot_pixel", {35'd0, vga_x, vga_y, vga_color}, {35'd0, m_pl.x, m_pl.y, m_pl.c});
                end
            end
        end
    end

    // One frame: derive the whole schedule from the rules, then drive it.
    // ovr_off: -1 no extra tick, -2 random extra tick, >0 extra tick at t0+ovr_off.
    task automatic run_frame(input logic [3:0] m, input bit force2, input int ovr_off);
        int s[4], w[4], lo[4], hi[4];
        int t0, tcur, fin, tend, ovr_cyc, active;
        logic [3:0] fexp, fl, rwe, rdone, v;
        logic [8:0] rx[4];
        logic [7:0] ry[4];
        logic [11:0] rc[4];
        logic [1:0] cexp;
        en_ev_t e;
        plot_ev_t p;
        st_ev_t st;

        @(posedge clock); #1;
        t0   = cyc;
        tcur = t0 + 1;
        fexp = 4'b0000;
        for (int i = 0; i < N; i++) begin
            lo[i] = tcur;
            if (m[i]) begin
                s[i] = tcur + 1;
                if (dly[i] >= 1 && dly[i] <= TMO) w[i] = dly[i];
                else begin
                    w[i] = TMO;
                    fexp[i] = 1'b1;
                end
                tcur = s[i] + w[i] + 1;
                v = 4'b0000;
                v[i] = 1'b1;
                e.cyc = s[i];
                e.val = v;
                en_q.push_back(e);
            end else begin
                s[i] = -100;
                w[i] = 0;
                tcur = tcur + 1;
            end
            hi[i] = tcur - 1;
        end
        fin = tcur;
        fd_q.push_back(fin);
        tend = fin + int'($urandom_range(0, 2));
        if (ovr_off == -2) ovr_cyc = int'($urandom_range(t0 + 1, fin));
        else if (ovr_off > 0) ovr_cyc = t0 + ovr_off;
        else ovr_cyc = -1;

        for (int t = t0; t <= tend; t++) begin
            if (t != t0) begin
                @(posedge clock); #1;
            end
            active = -1;
            for (int i = 0; i < N; i++)
                if (m[i] && t >= s[i] + 1 && t <= s[i] + w[i]) active = i;
            for (int i = 0; i < N; i++) begin
                rx[i]  = 9'($urandom);
                ry[i]  = 8'($urandom);
                rc[i]  = 12'($urandom);
                rwe[i] = 1'($urandom_range(0, 1));
                if (force2 && i == 2) begin
                    rwe[i] = 1'b1;
                    rx[i]  = 9'd5;
                    ry[i]  = 8'd7;
                end
                if (i == active) rdone[i] = !fexp[i] && (t == s[i] + w[i]);
                else rdone[i] = ($urandom_range(0, 3) == 0);
                client_x[9*i +: 9]      = rx[i];
                client_y[8*i +: 8]      = ry[i];
                client_color[12*i +: 12] = rc[i];
            end
            client_we   = rwe;
            client_done = rdone;
            frame_tick  = (t == t0) || (t == ovr_cyc);
            client_mask = (t == t0) ? m : 4'($urandom);
            if (t == ovr_cyc) ov_q.push_back(t);
            if (active >= 0 && rwe[active]) begin
                p.cyc = t + 1;
                p.x   = rx[active];
                p.y   = ry[active];
                p.c   = rc[active];
                plot_q.push_back(p);
            end
            if (t <= t0) cexp = cur_idle;
            else if (t >= fin) cexp = 2'd3;
            else begin
                cexp = 2'd0;
                for (int i = 0; i < N; i++)
                    if (t >= lo[i] && t <= hi[i]) cexp = 2'(i);
            end
            if (t <= t0) fl = prev_flags;
            else begin
                fl = 4'b0000;
                for (int i = 0; i < N; i++)
                    if (fexp[i] && t > s[i] + w[i]) fl[i] = 1'b1;
            end
            st.cyc   = t;
            st.bsy   = (t > t0) && (t <= fin);
            st.cur   = cexp;
            st.flags = fl;
            st_q.push_back(st);
        end
        cur_idle   = 2'd3;
        prev_flags = fexp;
    endtask

    task automatic drain_checks(input string tag);
        check({tag, "_en_q_left"},   64'(en_q.size()),   64'd0);
        check({tag, "_plot_q_left"}, 64'(plot_q.size()), 64'd0);
        check({tag, "_fd_q_left"},   64'(fd_q.size()),   64'd0);
        check({tag, "_ov_q_left"},   64'(ov_q.size()),   64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        resetn       = 1'b0;
        frame_tick   = 1'b0;
        client_mask  = '0;
        client_x     = '0;
        client_y     = '0;
        client_color = '0;
        client_we    = '0;
        client_done  = '0;
        cur_idle     = 2'd0;
        prev_flags   = 4'b0000;

        repeat (3) @(posedge clock);
        #1;
        check("reset_client_en", 64'(client_en), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_frame_done", 64'(frame_done), 64'd0);
        check("reset_vga", {35'd0, vga_plot, vga_x, vga_y, vga_color}, 64'd0);
        check("reset_cur_client", 64'(cur_client), 64'd0);
        check("reset_flags", 64'(timeout_flags), 64'd0);
        resetn = 1'b1;
        chk_en = 1'b1;

        // Full frame, every client done 10 cycles after its start.
        dly = '{10, 10, 10, 10};
        run_frame(4'b1111, 1'b0, -1);
        // Write isolation: client 2 hammers (5,7) while only client 1 runs.
        dly = '{0, 10, 0, 0};
        run_frame(4'b0010, 1'b1, -1);
        // Skip clients 1 and 3.
        dly = '{6, 0, 4, 0};
        run_frame(4'b0101, 1'b0, -1);
        // Empty mask.
        run_frame(4'b0000, 1'b0, -1);
        // Client 2 never finishes.
        dly = '{3, 5, 0, 4};
        run_frame(4'b1111, 1'b0, -1);
        // Done lands exactly on the last wait count.
        dly = '{2, 2, 16, 2};
        run_frame(4'b0100, 1'b0, -1);
        // Extra tick while client 0 is waiting.
        dly = '{10, 0, 0, 0};
        run_frame(4'b0001, 1'b0, 5);

        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < N; i++) dly[i] = int'($urandom_range(0, 20));
            run_frame(4'($urandom), 1'b0, ($urandom_range(0, 2) == 0) ? -2 : -1);
        end

        @(negedge clock);
        chk_en = 1'b0;
        drain_checks("pre_reset");

        // Reset in the middle of client 2's wait.
        @(posedge clock); #1;
        frame_tick  = 1'b1;
        client_mask = 4'b0100;
        client_we   = 4'b0100;
        client_done = 4'b0000;
        client_x[18 +: 9]     = 9'h1a5;
        client_y[16 +: 8]     = 8'h3c;
        client_color[24 +: 12] = 12'habc;
        @(posedge clock); #1;
        frame_tick = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_pre_client_en", 64'(client_en), 64'h4);
        repeat (2) @(posedge clock);
        #1;
        check("rst_pre_busy", 64'(busy), 64'd1);
        check("rst_pre_cur_client", 64'(cur_client), 64'd2);
        check("rst_pre_plot", {35'd0, vga_plot, vga_x, vga_y, vga_color}, {35'd0, 1'b1, 9'h1a5, 8'h3c, 12'habc});
        #2;
        resetn     = 1'b0;
        frame_tick = 1'b1;
        #1;
        check("rst_async_busy", 64'(busy), 64'd0);
        check("rst_async_vga", {35'd0, vga_plot, vga_x, vga_y, vga_color}, 64'd0);
        check("rst_async_cur_client", 64'(cur_client), 64'd0);
        check("rst_async_client_en", 64'(client_en), 64'd0);
        check("rst_async_overrun", 64'(overrun), 64'd0);
        check("rst_async_frame_done", 64'(frame_done), 64'd0);
        @(posedge clock); #1;
        check("rst_hold_busy", 64'(busy), 64'd0);
        #2;
        resetn      = 1'b1;
        frame_tick  = 1'b0;
        client_we   = 4'b0000;
        en_q.delete();
        plot_q.delete();
        fd_q.delete();
        ov_q.delete();
        st_q.delete();
        cur_idle   = 2'd0;
        prev_flags = 4'b0000;
        chk_en     = 1'b1;

        dly = '{5, 7, 0, 0};
        run_frame(4'b0011, 1'b0, -1);

        @(negedge clock);
        chk_en = 1'b0;
        drain_checks("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
